// File: rtl/ov5640_cfg_sequencer_if.sv
// Write-request channel between the OV5640 config sequencer (master) and the SCCB/I2C write engine (slave).
interface ov5640_cfg_sequencer_if;
  logic        req;
  logic [7:0]  dev_addr;
  logic [15:0] reg_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        nack;

  modport master (output req, dev_addr, reg_addr, wr_data, input busy, done, nack);
  modport slave  (input req, dev_addr, reg_addr, wr_data, output busy, done, nack);
endinterface

// File: rtl/ov5640_cfg_sequencer.sv
// Walks the OV5640 register LUT, issuing one I2C write per entry with power-up/soft-reset settle delays.
// Optional feature: define OV5640_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times.
module ov5640_cfg_sequencer #(
  parameter int          LUT_DEPTH = 1024,
  parameter logic [19:0] PWR_DLY   = 20'd1_000_000,
  parameter logic [19:0] SRST_DLY  = 20'd250_000,
  parameter int          MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start_i,
  output logic [9:0]           lut_index_o,
  input  logic [31:0]          lut_data_i,
  ov5640_cfg_sequencer_if.master i2c,
  output logic                 cfg_busy_o,
  output logic                 cfg_done_o,
  output logic                 cfg_error_o,
  output logic [9:0]           err_index_o
);

  if (LUT_DEPTH < 1 || LUT_DEPTH > 1024 || MAX_RETRY < 0) begin : g_bad_param
    $error("ov5640_cfg_sequencer: LUT_DEPTH must be 1..1024 and MAX_RETRY >= 0");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_ISSUE, S_WAIT, S_SRST, S_NEXT, S_DONE, S_ERR
  } state_t;

  // A zero delay still spends one cycle in the wait state.
  localparam logic [19:0] PWR_LAST  = (PWR_DLY  == 20'd0) ? 20'd0 : PWR_DLY  - 20'd1;
  localparam logic [19:0] SRST_LAST = (SRST_DLY == 20'd0) ? 20'd0 : SRST_DLY - 20'd1;
  localparam logic [9:0]  LAST_IDX  = 10'(LUT_DEPTH - 1);

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [9:0]  idx_q, eidx_q;
  logic [7:0]  dev_q, dat_q;
  logic [15:0] reg_q;
  logic        req_q, busy_q, done_q, err_q;

`ifdef OV5640_CFG_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q;
`endif

  logic srst_hit;
  assign srst_hit = (reg_q == 16'h3008) && dat_q[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      eidx_q  <= '0;
      dev_q   <= '0;
      reg_q   <= '0;
      dat_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef OV5640_CFG_RETRY_EN
      retry_q <= '0;
`endif
    end else begin
      req_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (cfg_start_i) begin
            state_q <= S_PWR;
            cnt_q   <= '0;
            idx_q   <= '0;
            eidx_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef OV5640_CFG_RETRY_EN
            retry_q <= '0;
`endif
          end
        end
        S_PWR: begin
          if (cnt_q == PWR_LAST) state_q <= S_FETCH;
          else                   cnt_q   <= cnt_q + 20'd1;
        end
        S_FETCH: begin
          if (lut_data_i[23:0] == 24'hffffff) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            dev_q   <= lut_data_i[31:24];
            reg_q   <= lut_data_i[23:8];
            dat_q   <= lut_data_i[7:0];
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i2c.busy) begin
            req_q   <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i2c.done) begin
            if (!i2c.nack) begin
              cnt_q   <= '0;
              state_q <= srst_hit ? S_SRST : S_NEXT;
`ifdef OV5640_CFG_RETRY_EN
            end else if (retry_q < RW'(MAX_RETRY)) begin
              retry_q <= retry_q + 1'b1;
              state_q <= S_ISSUE;
`endif
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              eidx_q  <= idx_q;
            end
          end
        end
        S_SRST: begin
          if (cnt_q == SRST_LAST) state_q <= S_NEXT;
          else                    cnt_q   <= cnt_q + 20'd1;
        end
        S_NEXT: begin
`ifdef OV5640_CFG_RETRY_EN
          retry_q <= '0;
`endif
          // Running off the table without a marker means a corrupt LUT.
          if (idx_q == LAST_IDX) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            eidx_q  <= idx_q;
          end else begin
            idx_q   <= idx_q + 10'd1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lut_index_o  = idx_q;
  assign i2c.req      = req_q;
  assign i2c.dev_addr = dev_q;
  assign i2c.reg_addr = reg_q;
  assign i2c.wr_data  = dat_q;
  assign cfg_busy_o   = busy_q;
  assign cfg_done_o   = done_q;
  assign cfg_error_o  = err_q;
  assign err_index_o  = eidx_q;

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Directed + randomized bench for ov5640_cfg_sequencer against a table-walk reference model.
module tb_ov5640_cfg_sequencer;
  localparam int          DEPTH = 8;
  localparam logic [19:0] PWR   = 20'd10;
  localparam logic [19:0] SRST  = 20'd100;
  localparam int          MAXR  = 3;
  localparam logic [31:0] MARK  = 32'h78ff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [9:0]  lut_index, err_index;
  logic [31:0] lut_data;
  logic        cfg_busy, cfg_done, cfg_error;
  logic [31:0] lut [0:DEPTH-1];
  int          nack_plan [0:DEPTH-1];
  int          nack_left [0:DEPTH-1];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          lat = 0;

  typedef struct {
    logic [9:0]  idx;
    logic [31:0] f;
    int          rc;
    int          dc;
  } txn_t;
  txn_t obs_q[$];
  int   exp_q[$];
  bit   exp_done;
  int   exp_fin;
  int   exp_eidx;

  ov5640_cfg_sequencer_if bus();

  ov5640_cfg_sequencer #(
    .LUT_DEPTH(DEPTH), .PWR_DLY(PWR), .SRST_DLY(SRST), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start_i(cfg_start),
    .lut_index_o(lut_index), .lut_data_i(lut_data), .i2c(bus),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .cfg_error_o(cfg_error),
    .err_index_o(err_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign lut_data = (lut_index < 10'(DEPTH)) ? lut[lut_index[2:0]] : 32'h0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, o, e);
    end
  endtask

  // I2C write engine model: busy for a random length, then done, NACKing per plan.
  always @(negedge clk) begin
    bus.done = 1'b0;
    bus.nack = 1'b0;
    if (rst) begin
      bus.busy = 1'b0;
      lat = 0;
    end else if (lat > 0) begin
      lat--;
      if (lat == 0 && obs_q.size() > 0) begin
        bus.done = 1'b1;
        bus.busy = 1'b0;
        chk("fields_held", {bus.dev_addr, bus.reg_addr, bus.wr_data}, obs_q[obs_q.size()-1].f);
        if (nack_left[obs_q[obs_q.size()-1].idx[2:0]] > 0) begin
          bus.nack = 1'b1;
          nack_left[obs_q[obs_q.size()-1].idx[2:0]]--;
        end
        obs_q[obs_q.size()-1].dc = cyc;
      end
    end else if (bus.req) begin
      bus.busy = 1'b1;
      lat = $urandom_range(1, 4);
      obs_q.push_back('{lut_index, {bus.dev_addr, bus.reg_addr, bus.wr_data}, cyc, 0});
    end
  end

  function automatic logic [31:0] rnd_entry();
    logic [7:0] r;
    r = 8'($urandom);
    if (r == 8'h08 || r == 8'hff) r = 8'h09;
    return {8'h78, 8'h30, r, 8'($urandom)};
  endfunction

  // Reference: walk the table, expanding each entry into its request attempts.
  task automatic model();
    int  i = 0;
    bit  fin = 0;
    exp_q.delete();
    exp_done = 0;
    exp_eidx = 0;
    while (!fin) begin
      if (lut[i][23:0] == 24'hffffff) begin
        exp_done = 1; exp_fin = i; fin = 1;
      end else begin
`ifdef OV5640_CFG_RETRY_EN
        if (nack_plan[i] > MAXR) begin
          repeat (MAXR + 1) exp_q.push_back(i);
          exp_eidx = i; exp_fin = i; fin = 1;
        end else begin
          repeat (nack_plan[i] + 1) exp_q.push_back(i);
        end
`else
        exp_q.push_back(i);
        if (nack_plan[i] > 0) begin
          exp_eidx = i; exp_fin = i; fin = 1;
        end
`endif
        if (!fin) begin
          if (i == DEPTH - 1) begin
            exp_eidx = i; exp_fin = i; fin = 1;
          end else i++;
        end
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cfg_busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, cfg_busy, 1'b0);
  endtask

  task automatic run(input string tag, input bit poke);
    int s, n, gap;
    model();
    for (int i = 0; i < DEPTH; i++) nack_left[i] = nack_plan[i];
    obs_q.delete();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    s = cyc;
    chk({tag, "_busy_on"}, cfg_busy, 1'b1);
    if (poke) begin
      n = 0;
      while (obs_q.size() == 0 && n < 500) begin @(negedge clk); n++; end
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
    end
    wait_idle(tag);
    repeat (6) @(negedge clk);
    chk({tag, "_nreq"}, obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      chk({tag, "_idx"}, obs_q[k].idx, exp_q[k]);
      chk({tag, "_fld"}, obs_q[k].f, lut[exp_q[k]]);
    end
    if (lut[0][23:0] != 24'hffffff && obs_q.size() > 0)
      chk({tag, "_pwr_lat"}, obs_q[0].rc - s, PWR + 2);
    chk({tag, "_done"}, cfg_done, exp_done);
    chk({tag, "_error"}, cfg_error, !exp_done);
    chk({tag, "_eidx"}, err_index, exp_eidx);
    chk({tag, "_lidx"}, lut_index, exp_fin);
    chk({tag, "_busy_off"}, cfg_busy, 1'b0);
    for (int k = 0; k + 1 < obs_q.size(); k++) begin
      if (obs_q[k].f[23:8] == 16'h3008 && obs_q[k + 1].idx != obs_q[k].idx) begin
        gap = obs_q[k + 1].rc - obs_q[k].dc;
        if (obs_q[k].f[7]) chk({tag, "_srst_gap"}, gap >= int'(SRST), 1'b1);
        else               chk({tag, "_nosrst_gap"}, gap < int'(SRST), 1'b1);
      end
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < DEPTH; i++) nack_plan[i] = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, bus.req, 1'b0);
    chk({tag, "_bus"}, {bus.dev_addr, bus.reg_addr, bus.wr_data}, 32'h0);
    chk({tag, "_status"}, {cfg_busy, cfg_done, cfg_error}, 3'b000);
    chk({tag, "_idx"}, {lut_index, err_index}, 20'h0);
  endtask

  initial begin
    int n;
    bus.busy = 1'b0; bus.done = 1'b0; bus.nack = 1'b0;
    clear_plan();
    for (int i = 0; i < DEPTH; i++) begin lut[i] = rnd_entry(); nack_left[i] = 0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    lut[4] = MARK;
    run("normal", 1'b1);

    for (int i = 0; i < DEPTH; i++) lut[i] = rnd_entry();
    lut[1] = 32'h7830_0882;
    lut[3] = 32'h7830_0842;
    lut[5] = MARK;
    run("srst", 1'b0);

    for (int i = 0; i < DEPTH; i++) lut[i] = rnd_entry();
    lut[4] = MARK;
    nack_plan[2] = 2;
    run("nack2", 1'b0);
    clear_plan();
    nack_plan[2] = 4;
    run("nack4", 1'b0);
    clear_plan();

    for (int i = 0; i < DEPTH; i++) lut[i] = rnd_entry();
    lut[7] = MARK;
    nack_plan[5] = 1;
    run("nack_e5", 1'b0);
    clear_plan();

    // Reset while the write to entry 0 is still on the bus.
    for (int i = 0; i < DEPTH; i++) nack_left[i] = 0;
    obs_q.delete();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    n = 0;
    while (obs_q.size() == 0 && n < 500) begin @(negedge clk); n++; end
    chk("midrst_reached_wait", obs_q.size() > 0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run("rerun", 1'b0);

    for (int i = 0; i < DEPTH; i++) lut[i] = rnd_entry();
    run("nomark", 1'b0);

    for (int it = 0; it < 6; it++) begin
      int mpos;
      mpos = $urandom_range(0, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        lut[i] = rnd_entry();
        if ($urandom_range(0, 4) == 0) lut[i][23:8] = 16'h3008;
        nack_plan[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      end
      if (mpos < DEPTH) lut[mpos] = MARK;
      run("rand", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
